serial_paralelo: RTL and testbench

Per-lane PHY receive front end on the 32f bit clock. It sits directly downstream of the TX paralelo_serial stage, at the far end of the serial link. It deserialises the MSB-first bit stream and byte-aligns on the COM symbol. After COM_LOCK consecutive aligned COM bytes it asserts active and presents one byte every 8 clocks to the downstream RX byte-to-word mux. Inside ACTIVE, COM bytes are flagged as not valid.

---
 rtl/serial_paralelo_pkg.sv | 18 +
 rtl/serial_shift_8.sv | 30 +++
 rtl/serial_paralelo.sv | 113 +++++++++++
 tb/tb_serial_paralelo.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/serial_paralelo_pkg.sv
// Shared RX definitions: the alignment symbol and the aligner FSM encoding.
package serial_paralelo_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] RX_COM = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_t;

  function automatic logic is_com(input logic [BYTE_W-1:0] b,
                                  input logic [BYTE_W-1:0] com);
    return (b == com);
  endfunction

endpackage

// File: rtl/serial_shift_8.sv
// MSB-first bit shifter with a mod-8 bit counter that can be snapped to a new byte phase.
module serial_shift_8
  import serial_paralelo_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bit,
  input  logic              i_realign,
  output logic [BYTE_W-1:0] o_cand,
  output logic              o_boundary
);

  logic [BYTE_W-1:0] r_sr;
  logic [2:0]        r_bit_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sr      <= '0;
      r_bit_cnt <= 3'd0;
    end else begin
      r_sr      <= o_cand;
      r_bit_cnt <= i_realign ? 3'd0 : r_bit_cnt + 3'd1;
    end
  end

  // Candidate includes the bit being sampled now, so a match is seen on its last bit.
  assign o_cand     = {r_sr[BYTE_W-2:0], i_bit};
  assign o_boundary = (r_bit_cnt == 3'd7);

endmodule

// File: rtl/serial_paralelo.sv
// Per-lane RX deserialiser: slides onto COM, locks after COM_LOCK aligned COMs, then emits a byte every 8 clocks.
module serial_paralelo
  import serial_paralelo_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COM      = RX_COM,
  parameter int                COM_LOCK = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  output logic              active,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              byte_strobe
);

  localparam logic [3:0] LOCK_LAST = 4'(COM_LOCK - 1);

  rx_state_t         r_state, w_state_nxt;
  logic [3:0]        r_com_cnt, w_com_cnt_nxt;
  logic              w_realign;
  logic [BYTE_W-1:0] w_cand;
  logic              w_boundary;
  logic              w_cand_com;

  logic              r_active, w_active_nxt;
  logic [BYTE_W-1:0] r_data;
  logic              r_valid;
  logic              r_strobe, w_strobe_nxt;

  serial_shift_8 u_shift (
    .i_clk      (clk_32f),
    .i_rst_n    (reset),
    .i_bit      (data_in),
    .i_realign  (w_realign),
    .o_cand     (w_cand),
    .o_boundary (w_boundary)
  );

  assign w_cand_com = is_com(w_cand, COM);

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      r_state   <= SEARCH;
      r_com_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_com_cnt <= w_com_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_com_cnt_nxt = r_com_cnt;
    w_realign     = 1'b0;
    unique case (r_state)
      SEARCH: begin
        if (w_cand_com) begin
          w_realign     = 1'b1;
          w_com_cnt_nxt = 4'd1;
          w_state_nxt   = (COM_LOCK == 1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        // A failed byte drops straight back to sliding; it is not re-scanned.
        if (w_boundary) begin
          if (!w_cand_com) begin
            w_com_cnt_nxt = 4'd0;
            w_state_nxt   = SEARCH;
          end else if (r_com_cnt == LOCK_LAST) begin
            w_state_nxt = ACTIVE;
          end else begin
            w_com_cnt_nxt = r_com_cnt + 4'd1;
          end
        end
      end
      ACTIVE: begin
        w_state_nxt = ACTIVE;
      end
      default: begin
        w_state_nxt   = SEARCH;
        w_com_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_comb begin
    w_active_nxt = (w_state_nxt == ACTIVE);
    w_strobe_nxt = (r_state == ACTIVE) && w_boundary;
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      r_active <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_active <= w_active_nxt;
      r_strobe <= w_strobe_nxt;
      if (w_strobe_nxt) begin
        r_data  <= w_cand;
        r_valid <= !w_cand_com;
      end
    end
  end

  assign active      = r_active;
  assign data_out    = r_data;
  assign valid_out   = r_valid;
  assign byte_strobe = r_strobe;

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench for serial_paralelo: reset, lock, payload strobes, misaligned lock, lock abort, re-lock.
module tb_serial_paralelo;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;
  logic       active;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] hold_data;
  logic       hold_valid;

  serial_paralelo dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .active      (active),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one bit, let the edge sample it, observe just after the edge.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  // a0: active expected after bits 0..6, a1: after the last bit.
  task automatic send_byte(input logic [7:0] b, input logic a0, input logic a1,
                           input logic stb, input logic [7:0] dexp, input logic vexp);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (i > 0) begin
        check_eq("active_mid", active, a0);
        check_eq("strobe_gap", byte_strobe, 0);
        check_eq("data_hold", data_out, hold_data);
        check_eq("valid_hold", valid_out, hold_valid);
      end else begin
        check_eq("active_end", active, a1);
        check_eq("strobe_end", byte_strobe, stb);
        if (stb) begin
          check_eq("data_out", data_out, dexp);
          check_eq("valid_out", valid_out, vexp);
          hold_data  = dexp;
          hold_valid = vexp;
        end else begin
          check_eq("data_nostb", data_out, hold_data);
        end
      end
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    send_bit(1'b1);
    check_eq("rst_outputs", {active, data_out, valid_out, byte_strobe}, 0);
    reset      = 1'b1;
    hold_data  = 8'h00;
    hold_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    data_in    = 1'b0;
    hold_data  = 8'h00;
    hold_valid = 1'b0;

    // Reset held with toggling input
    for (int i = 0; i < 5; i++) begin
      send_bit(i[0]);
      check_eq("reset_hold", {active, data_out, valid_out, byte_strobe}, 0);
    end
    reset = 1'b1;

    // Four COMs lock, fifth COM strobes with valid low
    send_byte(8'hBC, 0, 0, 0, 8'h00, 0);
    send_byte(8'hBC, 0, 0, 0, 8'h00, 0);
    send_byte(8'hBC, 0, 0, 0, 8'h00, 0);
    send_byte(8'hBC, 0, 1, 0, 8'h00, 0);
    send_byte(8'hBC, 1, 1, 1, 8'hBC, 0);

    // Payload bytes
    send_byte(8'hA5, 1, 1, 1, 8'hA5, 1);
    send_byte(8'h3C, 1, 1, 1, 8'h3C, 1);

    // Misaligned start: three junk bits then COMs
    pulse_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check_eq("junk_active", active, 0);
    send_byte(8'hBC, 0, 0, 0, 8'h00, 0);
    send_byte(8'hBC, 0, 0, 0, 8'h00, 0);
    send_byte(8'hBC, 0, 0, 0, 8'h00, 0);
    send_byte(8'hBC, 0, 1, 0, 8'h00, 0);
    send_byte(8'h5A, 1, 1, 1, 8'h5A, 1);

    // Lock aborted by a non-COM byte, then reacquired
    pulse_reset();
    send_byte(8'hBC, 0, 0, 0, 8'h00, 0);
    send_byte(8'hBC, 0, 0, 0, 8'h00, 0);
    send_byte(8'h00, 0, 0, 0, 8'h00, 0);
    send_byte(8'hBC, 0, 0, 0, 8'h00, 0);
    send_byte(8'hBC, 0, 0, 0, 8'h00, 0);
    send_byte(8'hBC, 0, 0, 0, 8'h00, 0);
    send_byte(8'hBC, 0, 1, 0, 8'h00, 0);
    send_byte(8'hBC, 1, 1, 1, 8'hBC, 0);
    send_byte(8'hE7, 1, 1, 1, 8'hE7, 1);

    // Reset pulse while ACTIVE forces a full re-lock
    pulse_reset();
    send_byte(8'hBC, 0, 0, 0, 8'h00, 0);
    send_byte(8'hBC, 0, 0, 0, 8'h00, 0);
    send_byte(8'hBC, 0, 0, 0, 8'h00, 0);
    send_byte(8'hBC, 0, 1, 0, 8'h00, 0);
    send_byte(8'h81, 1, 1, 1, 8'h81, 1);
    send_byte(8'hBC, 1, 1, 1, 8'hBC, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
